// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//
// Circular instruction buffer in the superscalar fetch front end. It holds
// fetched instructions while decode/issue stalls. It accepts up to two
// instructions per cycle from fetch and releases up to two per cycle to
// decode. A branch redirect flushes it.
//
// The head entry drives the queue-instruction input of the downstream
// queue/memory select mux. The non-empty flag drives that mux's
// check-queue select.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   iq_i_flush        discard all entries (synchronous, highest priority)
//   iq_i_wr_valid0/1  fetch slot valids (slot 0 is older)
//   iq_i_wr_instr0/1  fetch slot instructions
//   iq_i_rd_cnt       entries to pop this cycle (0..2, 3 treated as 2)
//   iq_o_instr0       head entry, or 0 when empty
//   iq_o_instr1       head+1 entry, or 0 when fewer than two entries
//   iq_o_check_queue  queue non-empty
//   iq_o_count        occupancy, 0..DEPTH
//   iq_o_ready        at least two free entries
//   iq_o_ovf          one-cycle pulse: a write was dropped
// -----------------------------------------------------------------------------
`ifndef IWIDTH
`define IWIDTH 32
`endif

module instr_queue #(
  parameter int IWIDTH = `IWIDTH,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iq_i_flush,
  input  logic              iq_i_wr_valid0,
  input  logic              iq_i_wr_valid1,
  input  logic [IWIDTH-1:0] iq_i_wr_instr0,
  input  logic [IWIDTH-1:0] iq_i_wr_instr1,
  input  logic [1:0]        iq_i_rd_cnt,
  output logic [IWIDTH-1:0] iq_o_instr0,
  output logic [IWIDTH-1:0] iq_o_instr1,
  output logic              iq_o_check_queue,
  output logic [AW:0]       iq_o_count,
  output logic              iq_o_ready,
  output logic              iq_o_ovf
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [IWIDTH-1:0] mem_q [DEPTH];

  logic [1:0]        push_cnt;
  logic [1:0]        rd_clip;
  logic [1:0]        pop_cnt;
  logic [AW:0]       free_cnt;
  logic              ready;
  logic              wr_req;
  logic              wr_accept;

  logic              wr_en0, wr_en1;
  logic [AW-1:0]     wr_idx0, wr_idx1;
  logic [IWIDTH-1:0] wr_dat0, wr_dat1;
  logic [AW-1:0]     head_p1;

  // Request decode. Acceptance and pop size both use the pre-edge
  // occupancy, so a pop in a full cycle never makes room for a
  // same-cycle write.
  always_comb begin
    push_cnt  = {1'b0, iq_i_wr_valid0} + {1'b0, iq_i_wr_valid1};
    rd_clip   = (iq_i_rd_cnt == 2'd3) ? 2'd2 : iq_i_rd_cnt;
    if ((AW+1)'(rd_clip) > count_q) begin
      pop_cnt = count_q[1:0];
    end else begin
      pop_cnt = rd_clip;
    end
    free_cnt  = DEPTH_C - count_q;
    ready     = (free_cnt >= (AW+1)'(2));
    wr_req    = (push_cnt != 2'd0);
    wr_accept = wr_req && ready && !iq_i_flush;
  end

  // Write compaction: the first valid slot always lands at tail. The
  // second slot lands at tail+1 only when both slots are valid.
  always_comb begin
    wr_en0  = wr_accept;
    wr_idx0 = tail_q;
    wr_dat0 = iq_i_wr_valid0 ? iq_i_wr_instr0 : iq_i_wr_instr1;
    wr_en1  = wr_accept && iq_i_wr_valid0 && iq_i_wr_valid1;
    wr_idx1 = tail_q + AW'(1);
    wr_dat1 = iq_i_wr_instr1;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (iq_i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      ovf_d  = wr_req && !ready;
      head_d = head_q + AW'(pop_cnt);
      if (wr_accept) begin
        tail_d = tail_q + AW'(push_cnt);
      end
      count_d = count_q - (AW+1)'(pop_cnt)
              + (wr_accept ? (AW+1)'(push_cnt) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries no reset. The read side masks entries that are not
  // valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem_q[wr_idx0] <= wr_dat0;
    end
    if (wr_en1) begin
      mem_q[wr_idx1] <= wr_dat1;
    end
  end

  always_comb begin
    head_p1          = head_q + AW'(1);
    iq_o_instr0      = (count_q != '0) ? mem_q[head_q] : '0;
    iq_o_instr1      = (count_q >= (AW+1)'(2)) ? mem_q[head_p1] : '0;
    iq_o_check_queue = (count_q != '0);
    iq_o_count       = count_q;
    iq_o_ready       = ready;
    iq_o_ovf         = ovf_q;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with hand-computed expectations.
module tb_instr_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        v0, v1;
  logic [31:0] i0, i1;
  logic [1:0]  rd;
  logic [31:0] o_i0, o_i1;
  logic        o_cq;
  logic [3:0]  o_cnt;
  logic        o_rdy;
  logic        o_ovf;

  int total = 0;
  int bad   = 0;

  instr_queue #(.IWIDTH(32), .DEPTH(8), .AW(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .iq_i_flush       (flush),
    .iq_i_wr_valid0   (v0),
    .iq_i_wr_valid1   (v1),
    .iq_i_wr_instr0   (i0),
    .iq_i_wr_instr1   (i1),
    .iq_i_rd_cnt      (rd),
    .iq_o_instr0      (o_i0),
    .iq_o_instr1      (o_i1),
    .iq_o_check_queue (o_cq),
    .iq_o_count       (o_cnt),
    .iq_o_ready       (o_rdy),
    .iq_o_ovf         (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    flush = 1'b0; v0 = 1'b0; v1 = 1'b0; i0 = '0; i1 = '0; rd = 2'd0;
  endtask

  // Apply one cycle of stimulus, then return 1 time unit after the edge
  // with inputs back at idle.
  task automatic cyc(input logic fl, input logic a, input logic b,
                     input logic [31:0] da, input logic [31:0] db,
                     input logic [1:0] r);
    flush = fl; v0 = a; v1 = b; i0 = da; i1 = db; rd = r;
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic state(input string tag, input logic [31:0] cnt,
                       input logic [31:0] e0, input logic [31:0] e1);
    chk({tag, "_cnt"}, 32'(o_cnt), cnt);
    chk({tag, "_i0"}, o_i0, e0);
    chk({tag, "_i1"}, o_i1, e1);
    chk({tag, "_cq"}, 32'(o_cq), (cnt != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    state("rst", 0, 0, 0);
    chk("rst_rdy", 32'(o_rdy), 1);
    chk("rst_ovf", 32'(o_ovf), 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    state("idle", 0, 0, 0);

    // dual push then dual pop
    cyc(0, 1, 1, 32'hcafecafe, 32'hfafafafa, 0);
    state("dual_push", 2, 32'hcafecafe, 32'hfafafafa);
    cyc(0, 0, 0, 0, 0, 2);
    state("dual_pop", 0, 0, 0);

    // fill to full (head=tail=2 at this point)
    cyc(0, 1, 1, 32'h1, 32'h2, 0);
    cyc(0, 1, 1, 32'h3, 32'h4, 0);
    cyc(0, 1, 1, 32'h5, 32'h6, 0);
    chk("six_rdy", 32'(o_rdy), 1);
    cyc(0, 1, 1, 32'h7, 32'h8, 0);
    state("full", 8, 32'h1, 32'h2);
    chk("full_rdy", 32'(o_rdy), 0);
    cyc(0, 1, 1, 32'h9, 32'hA, 0);
    state("drop", 8, 32'h1, 32'h2);
    chk("drop_ovf", 32'(o_ovf), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ovf_pulse", 32'(o_ovf), 0);
    cyc(0, 0, 0, 0, 0, 2);
    state("pop2", 6, 32'h3, 32'h4);
    chk("pop2_rdy", 32'(o_rdy), 1);
    cyc(0, 1, 1, 32'hB, 32'hC, 0);
    state("wrap", 8, 32'h3, 32'h4);
    // full-and-pop: write dropped even though the pop frees room
    cyc(0, 1, 1, 32'hD, 32'hE, 2);
    state("fullpop", 6, 32'h5, 32'h6);
    chk("fullpop_ovf", 32'(o_ovf), 1);
    cyc(0, 0, 0, 0, 0, 2);
    state("drain1", 4, 32'h7, 32'h8);
    cyc(0, 0, 0, 0, 0, 2);
    state("drain2", 2, 32'hB, 32'hC);
    cyc(0, 0, 0, 0, 0, 2);
    state("drain3", 0, 0, 0);

    // simultaneous push/pop
    cyc(0, 1, 1, 32'h10, 32'h11, 0);
    cyc(0, 1, 0, 32'h12, 32'h0, 0);
    state("three", 3, 32'h10, 32'h11);
    cyc(0, 0, 1, 32'hdead, 32'h13, 1);
    state("pushpop", 3, 32'h11, 32'h12);
    cyc(0, 0, 0, 0, 0, 2);
    state("after13", 1, 32'h13, 0);

    // over-pop
    cyc(0, 0, 0, 0, 0, 3);
    state("overpop", 0, 0, 0);
    cyc(0, 1, 0, 32'h40, 0, 0);
    state("postover", 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0, 1);
    state("postover_pop", 0, 0, 0);

    // flush priority
    cyc(0, 1, 1, 32'h50, 32'h51, 0);
    cyc(0, 1, 1, 32'h52, 32'h53, 0);
    cyc(0, 1, 0, 32'h54, 0, 0);
    state("five", 5, 32'h50, 32'h51);
    cyc(1, 1, 1, 32'h20, 32'h21, 2);
    state("flush", 0, 0, 0);
    chk("flush_ovf", 32'(o_ovf), 0);
    chk("flush_rdy", 32'(o_rdy), 1);
    // flush while full with a write pending: no overflow pulse
    repeat (4) cyc(0, 1, 1, 32'h60, 32'h61, 0);
    chk("refill", 32'(o_cnt), 8);
    cyc(1, 1, 1, 32'h62, 32'h63, 0);
    state("flushfull", 0, 0, 0);
    chk("flushfull_ovf", 32'(o_ovf), 0);
    cyc(0, 1, 0, 32'h30, 0, 0);
    state("post_flush", 1, 32'h30, 0);

    // asynchronous reset between edges
    cyc(0, 1, 1, 32'h31, 32'h32, 0);
    cyc(0, 0, 1, 0, 32'h33, 0);
    state("four", 4, 32'h30, 32'h31);
    #2;
    rst = 1'b0;
    #1;
    state("async", 0, 0, 0);
    chk("async_rdy", 32'(o_rdy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 1, 1, 32'h70, 32'h71, 0);
    state("post_rst", 2, 32'h70, 32'h71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
